// File: rtl/data_memory_mc_if.sv
// rtl/data_memory_mc_if.sv - request/response bus between the CPU datapath and data_memory_mc
interface data_memory_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_rdata;
    logic                      resp_error;
    logic                      busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/data_memory_mc.sv
// rtl/data_memory_mc.sv - multi-cycle data memory with programmable latency, byte enables and error reporting
module data_memory_mc #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int LATENCY        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clock,
    input  logic            reset,
    data_memory_mc_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;
    logic                  w_commit;
    logic                  w_accept;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NBYTES-1:0]     r_be;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NBYTES-1:0]     w_be;
    logic [IDXW-1:0]       w_idx;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_error;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // With LATENCY = 1 the commit edge is the accept edge, so the live bus feeds the commit path.
    assign w_write   = (r_state == S_IDLE) ? bus.req_write : r_write;
    assign w_addr    = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
    assign w_wdata   = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
    assign w_be      = (r_state == S_IDLE) ? bus.req_be    : r_be;

    assign w_idx          = w_addr[OFF +: IDXW];
    assign w_misaligned   = |(w_addr & ALIGN_MASK);
    assign w_out_of_range = |(w_addr >> (OFF + IDXW));
    assign w_error        = w_misaligned | w_out_of_range;
    assign w_rd_word      = r_mem[w_idx];

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_count_next = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if ((r_count == CW'(1)) || (r_count == '0)) begin
                    w_state_next = S_RESP;
                    w_count_next = '0;
                    w_commit     = 1'b1;
                end else begin
                    w_count_next = r_count - CW'(1);
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
            if (w_commit) begin
                r_error <= w_error;
                r_rdata <= (!w_write && !w_error) ? w_rd_word : '0;
            end else if (r_state == S_RESP) begin
                r_error <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end
        end else if (w_commit && w_write && !w_error) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;
endmodule

// File: tb/tb_data_memory_mc.sv
// tb/tb_data_memory_mc.sv - directed bench for data_memory_mc at latencies 2, 1, 4 and 3
module tb_data_memory_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  t_rst;
    logic [3:0]  t_valid;
    logic [3:0]  t_write;
    logic [31:0] t_addr  [4];
    logic [31:0] t_wdata [4];
    logic [3:0]  t_be    [4];
    logic [3:0]  t_ready;
    logic [3:0]  t_rvalid;
    logic [3:0]  t_rerr;
    logic [3:0]  t_busy;
    logic [31:0] t_rdata [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3;
        data_memory_mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
        assign bus.req_valid = t_valid[g];
        assign bus.req_write = t_write[g];
        assign bus.req_addr  = t_addr[g];
        assign bus.req_wdata = t_wdata[g];
        assign bus.req_be    = t_be[g];
        assign t_ready[g]    = bus.req_ready;
        assign t_rvalid[g]   = bus.resp_valid;
        assign t_rerr[g]     = bus.resp_error;
        assign t_busy[g]     = bus.busy;
        assign t_rdata[g]    = bus.resp_rdata;
        data_memory_mc #(
            .DATA_WIDTH(32), .DEPTH(128), .ADDR_WIDTH(32),
            .LATENCY(LAT), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clock(clk),
            .reset(t_rst[g]),
            .bus  (bus.slave)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int lat_of [4] = '{2, 1, 4, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat, output int rdy_lo);
        t_valid[d] = 1'b1;
        t_write[d] = wr;
        t_addr[d]  = a;
        t_wdata[d] = wd;
        t_be[d]    = be;
        @(negedge clk);
        t_valid[d] = 1'b0;
        t_write[d] = ~wr;
        t_addr[d]  = 32'h0000_0004;
        t_wdata[d] = 32'h5A5A_5A5A;
        t_be[d]    = 4'hF;
        lat    = 1;
        rdy_lo = 0;
        while (!t_rvalid[d] && lat < 20) begin
            if (!t_ready[d] && t_busy[d]) rdy_lo++;
            @(negedge clk);
            lat++;
        end
        if (!t_ready[d] && t_busy[d]) rdy_lo++;
        rd = t_rdata[d];
        er = t_rerr[d];
        @(negedge clk);
        chk($sformatf("post_resp_d%0d", d), {t_rvalid[d], t_rerr[d], t_ready[d], t_busy[d], t_rdata[d]},
            {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rl;
        int          pulses;

        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0042, 32'h0,         4'hF, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h0000_01FC, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0040, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};

        t_rst   = 4'hF;
        t_valid = 4'h0;
        t_write = 4'h0;
        for (int d = 0; d < 4; d++) begin
            t_addr[d]  = '0;
            t_wdata[d] = '0;
            t_be[d]    = '0;
        end
        repeat (3) @(negedge clk);
        t_rst = 4'h0;
        @(negedge clk);

        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_outputs_d%0d", d),
                {t_ready[d], t_busy[d], t_rvalid[d], t_rerr[d], t_rdata[d]},
                {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        end

        for (int a = 0; a < 32'h200; a += 32'h24) begin
            txn(0, 1'b0, 32'(a), 32'h0, 4'h0, rd, er, lat, rl);
            chk($sformatf("reset_word_%0h", a), {er, rd}, {1'b0, 32'h0});
        end

        for (int i = 0; i < 14; i++) begin
            txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, rl);
            chk($sformatf("vec%0d_resp", i), {er, rd}, {vecs[i].exp_err, vecs[i].exp_rd});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(lat_of[0]));
            chk($sformatf("vec%0d_ready_low", i), 64'(rl), 64'(lat_of[0]));
        end

        for (int d = 1; d < 3; d++) begin
            txn(d, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hF, rd, er, lat, rl);
            chk($sformatf("lat_wr_d%0d", d), {er, rd, 32'(lat), 32'(rl)},
                {1'b0, 32'h0, 32'(lat_of[d]), 32'(lat_of[d])});
            txn(d, 1'b0, 32'h0000_0080, 32'h0, 4'h0, rd, er, lat, rl);
            chk($sformatf("lat_rd_d%0d", d), {er, rd, 32'(lat), 32'(rl)},
                {1'b0, 32'h0BAD_F00D, 32'(lat_of[d]), 32'(lat_of[d])});
        end

        // A request pulsed while the LATENCY=4 instance waits must be dropped.
        t_valid[2] = 1'b1; t_write[2] = 1'b0; t_addr[2] = 32'h80; t_be[2] = 4'h0;
        @(negedge clk);
        t_valid[2] = 1'b1; t_write[2] = 1'b1; t_addr[2] = 32'h0; t_wdata[2] = 32'hFFFF_FFFF; t_be[2] = 4'hF;
        pulses = 0;
        @(negedge clk);
        t_valid[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (t_rvalid[2]) begin
                pulses++;
                chk("wait_pulse_rdata", {t_rerr[2], t_rdata[2]}, {1'b0, 32'h0BAD_F00D});
            end
            @(negedge clk);
        end
        chk("wait_pulse_count", 64'(pulses), 64'd1);
        txn(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rl);
        chk("wait_pulse_no_write", {er, rd}, {1'b0, 32'h0});

        // LATENCY=3: reset one cycle after accept drops the write.
        t_valid[3] = 1'b1; t_write[3] = 1'b1; t_addr[3] = 32'h10; t_wdata[3] = 32'hAAAA_5555; t_be[3] = 4'hF;
        @(negedge clk);
        t_valid[3] = 1'b0;
        t_rst[3]   = 1'b1;
        pulses = 0;
        @(negedge clk);
        t_rst[3] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (t_rvalid[3]) pulses++;
            @(negedge clk);
        end
        chk("midreset_no_resp", 64'(pulses), 64'd0);
        chk("midreset_idle", {t_ready[3], t_busy[3]}, {1'b1, 1'b0});
        txn(3, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rl);
        chk("midreset_read", {er, rd, 32'(lat)}, {1'b0, 32'h0, 32'd3});

        // Reset coincident with req_valid: nothing accepted.
        t_rst[3] = 1'b1; t_valid[3] = 1'b1; t_write[3] = 1'b1; t_addr[3] = 32'h10;
        @(negedge clk);
        t_rst[3] = 1'b0; t_valid[3] = 1'b0;
        chk("reset_with_valid", {t_ready[3], t_busy[3]}, {1'b1, 1'b0});
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (t_rvalid[3]) pulses++;
            @(negedge clk);
        end
        chk("reset_with_valid_no_resp", 64'(pulses), 64'd0);
        txn(3, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rl);
        chk("reset_with_valid_read", {er, rd}, {1'b0, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
